// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receiver supervisor: frame tracking, 4-deep RX FIFO, error counters, safe config apply
module uart_rx_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       rx_data_valid,
    input  logic [7:0] rx_p_data,
    input  logic       rx_parity_error,
    input  logic       rx_stop_error,
    input  logic       cfg_wr,
    input  logic [5:0] cfg_prescale,
    input  logic       cfg_par_en,
    input  logic       cfg_par_typ,
    output logic [5:0] prescale,
    output logic       par_en,
    output logic       par_typ,
    output logic       cfg_pending,
    output logic       cfg_err,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    input  logic       clr_cnt,
    output logic [7:0] par_err_cnt,
    output logic [7:0] stop_err_cnt,
    output logic [7:0] ovf_cnt,
    output logic [7:0] tmo_cnt,
    output logic       busy
);
    typedef enum logic {S_IDLE = 1'b0, S_FRAME = 1'b1} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_rx_q;
    logic [8:0]  r_tmo;
    logic [8:0]  w_tmo_limit;
    logic        w_start, w_any_ind, w_tmo_hit;
    logic        w_par_inc, w_stop_inc, w_push_req, w_tmo_inc, w_apply;
    logic        w_full, w_push, w_pop;
    logic [7:0]  r_mem [0:3];
    logic [1:0]  r_wr_ptr, r_rd_ptr;
    logic [2:0]  r_count;
    logic [5:0]  r_prescale, r_pend_prescale;
    logic        r_par_en, r_par_typ, r_pend_par_en, r_pend_par_typ;
    logic        r_cfg_pending, r_cfg_err;
    logic [7:0]  r_par_cnt, r_stop_cnt, r_ovf_cnt, r_tmo_cnt;
    logic        w_cfg_legal;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign w_start     = (r_state == S_IDLE) && r_rx_q && !rx_in;
    assign w_any_ind   = rx_data_valid | rx_parity_error | rx_stop_error;
    assign w_tmo_limit = ({3'd0, r_prescale} * 9'd12) - 9'd1;
    assign w_tmo_hit   = (r_tmo == w_tmo_limit);
    assign w_cfg_legal = (cfg_prescale == 6'd8) || (cfg_prescale == 6'd16) || (cfg_prescale == 6'd32);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rx_q  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_rx_q  <= rx_in;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next_state = S_FRAME;
            S_FRAME: if (w_any_ind || w_tmo_hit) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // An end indication wins over a timeout landing on the same cycle.
    always_comb begin
        busy       = (r_state == S_FRAME);
        w_par_inc  = busy && rx_parity_error;
        w_stop_inc = busy && rx_stop_error;
        w_push_req = busy && rx_data_valid && !rx_parity_error && !rx_stop_error;
        w_tmo_inc  = busy && !w_any_ind && w_tmo_hit;
        w_apply    = (r_state == S_IDLE) && !w_start && r_cfg_pending;
    end

    always_ff @(posedge clk) begin
        if (rst || w_start) r_tmo <= 9'd0;
        else if (busy)      r_tmo <= r_tmo + 9'd1;
    end

    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign w_full  = (r_count == 3'd4);
    assign w_pop   = m_valid && m_ready;
    assign w_push  = w_push_req && (!w_full || w_pop);
    assign m_valid = (r_count != 3'd0);
    assign m_data  = m_valid ? r_mem[r_rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
            for (int i = 0; i < 4; i++) r_mem[i] <= 8'h00;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= rx_p_data;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            r_par_cnt  <= 8'd0;
            r_stop_cnt <= 8'd0;
            r_ovf_cnt  <= 8'd0;
            r_tmo_cnt  <= 8'd0;
        end else begin
            if (w_par_inc)                      r_par_cnt  <= sat_inc(r_par_cnt);
            if (w_stop_inc)                     r_stop_cnt <= sat_inc(r_stop_cnt);
            if (w_push_req && w_full && !w_pop) r_ovf_cnt  <= sat_inc(r_ovf_cnt);
            if (w_tmo_inc)                      r_tmo_cnt  <= sat_inc(r_tmo_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale      <= 6'd8;
            r_par_en        <= 1'b0;
            r_par_typ       <= 1'b0;
            r_pend_prescale <= 6'd8;
            r_pend_par_en   <= 1'b0;
            r_pend_par_typ  <= 1'b0;
            r_cfg_pending   <= 1'b0;
            r_cfg_err       <= 1'b0;
        end else begin
            r_cfg_err <= cfg_wr && !w_cfg_legal;
            if (w_apply) begin
                r_prescale    <= r_pend_prescale;
                r_par_en      <= r_pend_par_en;
                r_par_typ     <= r_pend_par_typ;
                r_cfg_pending <= 1'b0;
            end
            // A fresh legal write re-arms pending even if the old value applies now.
            if (cfg_wr && w_cfg_legal) begin
                r_pend_prescale <= cfg_prescale;
                r_pend_par_en   <= cfg_par_en;
                r_pend_par_typ  <= cfg_par_typ;
                r_cfg_pending   <= 1'b1;
            end
        end
    end

    assign prescale     = r_prescale;
    assign par_en       = r_par_en;
    assign par_typ      = r_par_typ;
    assign cfg_pending  = r_cfg_pending;
    assign cfg_err      = r_cfg_err;
    assign par_err_cnt  = r_par_cnt;
    assign stop_err_cnt = r_stop_cnt;
    assign ovf_cnt      = r_ovf_cnt;
    assign tmo_cnt      = r_tmo_cnt;
endmodule
